// File: rtl/calc_sequencer_if.sv
// Program-ROM and ALU connection bundle for the calculator sequencer.
// The sequencer is the master; the ROM/ALU side is the slave.
interface calc_sequencer_if #(
  parameter int PC_W = 6
);
  logic [PC_W-1:0] prog_addr;
  logic [17:0]     prog_data;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [3:0]      alu_sel;
  logic [7:0]      alu_y;
  logic            alu_cout;

  modport master (
    output prog_addr, alu_a, alu_b, alu_sel,
    input  prog_data, alu_y, alu_cout
  );

  modport slave (
    input  prog_addr, alu_a, alu_b, alu_sel,
    output prog_data, alu_y, alu_cout
  );
endinterface

// File: rtl/calc_sequencer.sv
// Three-cycle fetch/decode/execute sequencer with a 4x8 register file,
// carry/zero flags and conditional branches, driving an external 8-bit ALU.
module calc_sequencer #(
  parameter int PC_W  = 6,
  parameter int NREGS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  calc_sequencer_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              carry_flag,
  output logic              zero_flag,
  input  logic [1:0]        dbg_sel,
  output logic [7:0]        dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic [17:0]     r_ir;
  logic [7:0]      r_regs [NREGS];
  logic            r_c;
  logic            r_z;
  logic            r_done;

  logic [1:0]      w_class;
  logic [3:0]      w_sel;
  logic [1:0]      w_rd;
  logic [1:0]      w_rs;
  logic [7:0]      w_imm;
  logic [7:0]      w_op_a;
  logic [7:0]      w_op_b;
  logic            w_taken;
  logic            w_reg_we;
  logic            w_done_next;
  logic [7:0]      w_alu_a;
  logic [7:0]      w_alu_b;
  logic [3:0]      w_alu_sel;

  assign w_class  = r_ir[17:16];
  assign w_sel    = r_ir[15:12];
  assign w_rd     = r_ir[11:10];
  assign w_rs     = r_ir[9:8];
  assign w_imm    = r_ir[7:0];
  assign w_op_a   = r_regs[w_rd];
  assign w_op_b   = (w_class == 2'b00) ? r_regs[w_rs] : w_imm;
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_target = w_imm[PC_W-1:0];

  // Branch condition uses only the low two bits of the cond field.
  always_comb begin
    w_taken = 1'b0;
    unique case (w_sel[1:0])
      2'b00: w_taken = 1'b1;
      2'b01: w_taken = r_c;
      2'b10: w_taken = r_z;
      2'b11: w_taken = ~r_z;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_reg_we     = 1'b0;
    w_done_next  = 1'b0;
    w_alu_a      = 8'd0;
    w_alu_b      = 8'd0;
    w_alu_sel    = 4'd0;
    unique case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          w_state_next = S_FETCH;
          w_pc_next    = '0;
        end
      end
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        unique case (w_class)
          2'b00, 2'b01: begin
            w_alu_a      = w_op_a;
            w_alu_b      = w_op_b;
            w_alu_sel    = w_sel;
            w_reg_we     = 1'b1;
            w_pc_next    = w_pc_inc;
            w_state_next = S_FETCH;
          end
          2'b10: begin
            w_pc_next    = w_taken ? w_target : w_pc_inc;
            w_state_next = S_FETCH;
          end
          default: begin
            w_state_next = S_HALTED;
            w_done_next  = 1'b1;
          end
        endcase
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 8'd0;
      end
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_done  <= w_done_next;
      if (r_state == S_DECODE) begin
        r_ir <= bus.prog_data;
      end
      if (w_reg_we) begin
        r_regs[w_rd] <= bus.alu_y;
        r_c          <= bus.alu_cout;
        r_z          <= (bus.alu_y == 8'd0);
      end
    end
  end

  assign bus.prog_addr = r_pc;
  assign bus.alu_a     = w_alu_a;
  assign bus.alu_b     = w_alu_b;
  assign bus.alu_sel   = w_alu_sel;

  assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
  assign done       = r_done;
  assign carry_flag = r_c;
  assign zero_flag  = r_z;
  assign dbg_data   = r_regs[dbg_sel];

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: an ISA-level interpreter predicts the
// PC trace and final register/flag state, a monitor compares as the DUT runs.
module tb_calc_sequencer;

  localparam int PC_W  = 4;
  localparam int DEPTH = 1 << PC_W;

  typedef struct {
    logic [3:0][7:0] regs;
    logic            c;
    logic            z;
    int              cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, carry_flag, zero_flag;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;
  logic [1:0] stim_sel = 2'd0;
  logic [1:0] mon_sel = 2'd0;
  bit         stim_dbg = 1'b1;
  bit         mon_en = 1'b0;

  logic [17:0] rom [DEPTH];
  logic [7:0]  m_regs [4];
  logic        m_c, m_z;
  exp_t        exp_q [$];
  int          exp_pc_q [$];
  int          vectors = 0;
  int          errors = 0;
  int          runs = 0;

  calc_sequencer_if #(.PC_W(PC_W)) bus ();

  calc_sequencer #(.PC_W(PC_W), .NREGS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  assign dbg_sel = stim_dbg ? stim_sel : mon_sel;

  // External ALU model: any op set, carry is always that of A+B.
  function automatic logic [7:0] alu_fn(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return b;
      4'd3:    return b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd14:   return a - 8'd1;
      4'd15:   return a + 8'd1;
      default: return a;
    endcase
  endfunction

  logic [8:0] alu_sum;
  assign alu_sum      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_cout = alu_sum[8];
  assign bus.alu_y    = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

  always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

  function automatic logic [17:0] enc(input logic [1:0] cls, input logic [3:0] sel,
                                      input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    return {cls, sel, rd, rs, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Instruction-level interpreter: walks the program and records every PC executed.
  task automatic model_run(output int n);
    int          pc;
    logic [17:0] ins;
    logic [7:0]  a, b, y;
    logic [8:0]  s;
    bit          taken;
    exp_t        e;
    pc = 0;
    n  = 0;
    while (n < 1000) begin
      ins = rom[pc];
      exp_pc_q.push_back(pc);
      n++;
      if (ins[17:16] == 2'b11) break;
      if (ins[17] == 1'b0) begin
        a = m_regs[ins[11:10]];
        b = ins[16] ? ins[7:0] : m_regs[ins[9:8]];
        y = alu_fn(ins[15:12], a, b);
        s = {1'b0, a} + {1'b0, b};
        m_regs[ins[11:10]] = y;
        m_c = s[8];
        m_z = (y == 8'd0);
        pc = (pc + 1) % DEPTH;
      end else begin
        case (ins[13:12])
          2'b00:   taken = 1'b1;
          2'b01:   taken = m_c;
          2'b10:   taken = m_z;
          default: taken = !m_z;
        endcase
        pc = taken ? (int'(ins[7:0]) % DEPTH) : ((pc + 1) % DEPTH);
      end
    end
    for (int i = 0; i < 4; i++) e.regs[i] = m_regs[i];
    e.c = m_c;
    e.z = m_z;
    e.cycles = 3 * n;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
    m_c = 1'b0;
    m_z = 1'b0;
    exp_q.delete();
    exp_pc_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    stim_dbg = 1'b1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_prog_addr"}, bus.prog_addr, 0);
    check({tag, "_alu_sel"}, bus.alu_sel, 0);
    check({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 0);
    check({tag, "_carry"}, carry_flag, 0);
    check({tag, "_zero"}, zero_flag, 0);
    for (int i = 0; i < 4; i++) begin
      stim_sel = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, 0);
    end
    stim_dbg = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic run_prog(input string name, input bit mid_start);
    int n;
    int k;
    model_run(n);
    runs++;
    $display("run %0d %s: %0d instructions expected, mid_start=%0d", runs, name, n, mid_start);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (mid_start) begin
      repeat (3) @(negedge clk);
      if (busy) begin
        start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
    end
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check({name, "_done_timeout"}, 1, 0);
      do_reset();
    end else begin
      @(negedge clk);
      check({name, "_done_width"}, done, 0);
    end
    @(negedge clk);
  endtask

  // Monitor: checks the PC at each FETCH and the architectural state on done.
  initial begin : monitor
    int   cyc;
    int   t0;
    int   phase;
    int   epc;
    bit   prev_busy;
    exp_t e;
    cyc = 0;
    t0 = 0;
    phase = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        prev_busy = busy;
        phase = 0;
        continue;
      end
      if (busy && !prev_busy) begin
        t0 = cyc;
        phase = 0;
      end
      if (busy) begin
        if (phase == 0) begin
          if (exp_pc_q.size() == 0) begin
            check("pc_unexpected_fetch", 1, 0);
          end else begin
            epc = exp_pc_q.pop_front();
            check("pc_trace", bus.prog_addr, epc);
          end
          check("alu_idle_in_fetch", {bus.alu_sel, bus.alu_a, bus.alu_b}, 0);
        end
        phase = (phase == 2) ? 0 : phase + 1;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("busy_at_done", busy, 0);
          check("cycles", cyc - t0, e.cycles);
          check("carry", carry_flag, e.c);
          check("zero", zero_flag, e.z);
          for (int i = 0; i < 4; i++) begin
            mon_sel = 2'(i);
            #1;
            check($sformatf("r%0d", i), dbg_data, e.regs[i]);
          end
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : stimulus
    logic [1:0] cls;
    int         r;
    model_clear();
    for (int i = 0; i < DEPTH; i++) rom[i] = enc(2'b11, 4'd0, 2'd0, 2'd0, 8'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("por");
    mon_en = 1'b1;

    // Add with carry
    rom[0] = enc(2'b01, 4'd3, 2'd1, 2'd0, 8'hC8);
    rom[1] = enc(2'b01, 4'd3, 2'd2, 2'd0, 8'h64);
    rom[2] = enc(2'b00, 4'd0, 2'd1, 2'd2, 8'h00);
    rom[3] = enc(2'b11, 4'd0, 2'd0, 2'd0, 8'h00);
    run_prog("add_carry", 1'b0);

    // Restart from HALTED keeps registers: R1 = 0x2C + 0x64
    rom[0] = enc(2'b00, 4'd0, 2'd1, 2'd2, 8'h00);
    rom[1] = enc(2'b11, 4'd0, 2'd0, 2'd0, 8'h00);
    run_prog("restart_keep_regs", 1'b0);

    // Countdown loop, with a stray start pulse while busy
    rom[0] = enc(2'b01, 4'd3, 2'd0, 2'd0, 8'd3);
    rom[1] = enc(2'b01, 4'd14, 2'd0, 2'd0, 8'd0);
    rom[2] = enc(2'b10, 4'b0011, 2'd0, 2'd0, 8'd1);
    rom[3] = enc(2'b11, 4'd0, 2'd0, 2'd0, 8'h00);
    run_prog("loop", 1'b1);

    // Branch not taken: C cleared, Z set, then BR C
    for (int i = 0; i < DEPTH; i++) rom[i] = enc(2'b11, 4'd0, 2'd0, 2'd0, 8'd0);
    rom[0] = enc(2'b01, 4'd4, 2'd0, 2'd0, 8'h00);
    rom[1] = enc(2'b10, 4'b0001, 2'd0, 2'd0, 8'h20);
    run_prog("branch_not_taken", 1'b0);

    // PC wrap: enters with Z=1, jumps to 14, runs 14, 15, 0, 1(HALT)
    for (int i = 0; i < DEPTH; i++) rom[i] = enc(2'b00, 4'd2, 2'd0, 2'd0, 8'd0);
    rom[0]  = enc(2'b10, 4'b0010, 2'd0, 2'd0, 8'd14);
    rom[1]  = enc(2'b11, 4'd0, 2'd0, 2'd0, 8'd0);
    rom[14] = enc(2'b01, 4'd5, 2'd1, 2'd0, 8'd1);
    rom[15] = enc(2'b01, 4'd5, 2'd1, 2'd0, 8'd1);
    run_prog("pc_wrap", 1'b0);

    // Random programs: forward-only branches so every program halts
    for (int p = 0; p < 25; p++) begin
      for (int a = 0; a < DEPTH - 1; a++) begin
        r = $urandom_range(0, 13);
        if (r < 9) begin
          cls = (r < 4) ? 2'b00 : 2'b01;
          rom[a] = enc(cls, 4'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
        end else if (r < 13) begin
          rom[a] = enc(2'b10, 4'($urandom), 2'($urandom), 2'($urandom),
                       {4'($urandom), 4'($urandom_range(a + 1, DEPTH - 1))});
        end else begin
          rom[a] = enc(2'b11, 4'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
        end
      end
      rom[DEPTH-1] = enc(2'b11, 4'd0, 2'd0, 2'd0, 8'd0);
      run_prog($sformatf("random%0d", p), 1'($urandom_range(0, 1)));
    end

    // Reset during EXEC of the first instruction
    mon_en = 1'b0;
    rom[0] = enc(2'b01, 4'd3, 2'd0, 2'd0, 8'd3);
    rom[1] = enc(2'b01, 4'd14, 2'd0, 2'd0, 8'd0);
    rom[2] = enc(2'b10, 4'b0011, 2'd0, 2'd0, 8'd1);
    rom[3] = enc(2'b11, 4'd0, 2'd0, 2'd0, 8'h00);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    check_reset_state("mid_exec_reset");
    model_clear();
    @(negedge clk);
    mon_en = 1'b1;
    run_prog("after_reset_loop", 1'b0);

    check("scoreboard_drained", exp_q.size() + exp_pc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
